// File: rtl/hc_sr_pkg.sv
// Shared definitions for the HC-SR04 sensor emulator: FSM state encoding,
// default timing constants, counter width and the jitter LFSR step function.
package hc_sr_pkg;

  // Width of every µs-domain counter (trig width, burst, echo length, holdoff).
  localparam int unsigned CntW = 16;

  // FSM state encoding.
  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StTrigHi  = 3'd1;
  localparam logic [2:0] StBurst   = 3'd2;
  localparam logic [2:0] StEcho    = 3'd3;
  localparam logic [2:0] StHoldoff = 3'd4;

  // Default timing constants; the top-level parameters default to these.
  localparam int unsigned DefUsPerCm   = 58;
  localparam int unsigned DefMinTrigUs = 10;
  localparam int unsigned DefTimeoutUs = 38000;
  localparam int unsigned DefMaxCm     = 400;

  // Jitter LFSR: 16-bit Galois form, maximal-length taps.
  localparam logic [15:0] LfsrSeed = 16'hACE1;
  localparam logic [15:0] LfsrTaps = 16'hB400;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? LfsrTaps : 16'h0000);
  endfunction

endpackage

// File: rtl/hc_sr_us_tick.sv
// Microsecond tick generator: a free-running divider that raises a one-cycle
// enable every CLK_FREQ_MHZ clocks, so the rest of the design stays on Clk.
module hc_sr_us_tick #(
  parameter int unsigned CLK_FREQ_MHZ = 50
) (
  input  logic Clk,
  input  logic Rst_n,
  output logic tick
);

  localparam int unsigned W = (CLK_FREQ_MHZ > 1) ? $clog2(CLK_FREQ_MHZ) : 1;
  localparam logic [W-1:0] Last = W'(CLK_FREQ_MHZ - 1);
  localparam logic [W-1:0] One  = W'(1);

  logic [W-1:0] cnt_q, cnt_d;

  // Next divider value: count up, wrap after the last cycle of the µs.
  always_comb begin
    cnt_d = (cnt_q == Last) ? '0 : cnt_q + One;
  end

  // Divider register.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == Last);

endmodule

// File: rtl/hc_sr_sensor_emu.sv
// HC-SR04 ultrasonic sensor emulator (responder side of trig/echo).
// Qualifies the host trig width, waits the emulated burst time, then drives
// echo high for a width proportional to the distance latched at qualification.
// Optional build macro: HC_SR_SENSOR_EMU_JITTER_EN adds LFSR-driven -4..+3 µs
// jitter to in-range echo lengths.
module hc_sr_sensor_emu
  import hc_sr_pkg::*;
#(
  parameter int unsigned CLK_FREQ_MHZ = 50,
  parameter int unsigned MIN_TRIG_US  = DefMinTrigUs,
  parameter int unsigned BURST_US     = 200,
  parameter int unsigned US_PER_CM    = DefUsPerCm,
  parameter int unsigned MAX_CM       = DefMaxCm,
  parameter int unsigned TIMEOUT_US   = DefTimeoutUs,
  parameter int unsigned HOLDOFF_US   = 1000
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       trig,
  input  logic [8:0] dist_cm,
  output logic       echo,
  output logic       busy,
  output logic       short_trig,
  output logic       meas_done
);

  // All durations must fit the 16-bit counters; in-range lengths leave room
  // for the +3 jitter offset. Zero-length intervals are not representable.
  if (MIN_TRIG_US > 65535 || BURST_US > 65535 || TIMEOUT_US > 65535 ||
      HOLDOFF_US > 65535 || MAX_CM > 65535 || US_PER_CM > 65535 ||
      MAX_CM * US_PER_CM > 65532 || BURST_US < 1 || HOLDOFF_US < 1 ||
      TIMEOUT_US < 1 || US_PER_CM < 1 || CLK_FREQ_MHZ < 1) begin : g_param_chk
    $error("hc_sr_sensor_emu: duration parameter out of range");
  end

  localparam logic [CntW-1:0] One       = CntW'(1);
  localparam logic [CntW-1:0] MinTrig   = CntW'(MIN_TRIG_US);
  localparam logic [CntW-1:0] BurstLast = CntW'(BURST_US - 1);
  localparam logic [CntW-1:0] HoldLast  = CntW'(HOLDOFF_US - 1);
  localparam logic [CntW-1:0] Timeout   = CntW'(TIMEOUT_US);
  localparam logic [CntW-1:0] MaxCm     = CntW'(MAX_CM);

  logic            tick;
  logic            trig_s1_q, trig_s1_d;
  logic            trig_s2_q, trig_s2_d;
  logic            trig_p_q, trig_p_d;
  logic            trig_rise, trig_fall;
  logic [2:0]      state_q, state_d;
  logic [CntW-1:0] tmr_q, tmr_d;
  logic [CntW-1:0] len_q, len_d;
  logic [8:0]      dist_q, dist_d;
  logic            echo_q, echo_d;
  logic            short_q, short_d;
  logic            done_q, done_d;
  logic            in_range;
  logic [CntW-1:0] base_len;
  logic [CntW-1:0] range_len;
  logic [CntW-1:0] echo_len;

  hc_sr_us_tick #(
    .CLK_FREQ_MHZ(CLK_FREQ_MHZ)
  ) u_tick (
    .Clk  (Clk),
    .Rst_n(Rst_n),
    .tick (tick)
  );

  // Two-flop synchroniser plus a history flop for edge detection.
  always_comb begin
    trig_s1_d = trig;
    trig_s2_d = trig_s1_q;
    trig_p_d  = trig_s2_q;
  end

  assign trig_rise = trig_s2_q & ~trig_p_q;
  assign trig_fall = ~trig_s2_q & trig_p_q;

  // Echo length from the latched distance; out-of-range and zero map to timeout.
  always_comb begin
    in_range = (dist_q != 9'd0) && (CntW'(dist_q) <= MaxCm);
    base_len = CntW'(32'(dist_q) * US_PER_CM);
  end

`ifdef HC_SR_SENSOR_EMU_JITTER_EN
  logic [15:0]            lfsr_q, lfsr_d;
  logic signed [CntW+1:0] jit_sum;

  // Offset LFSR[2:0]-4 gives -4..+3; result clamped so echo is never empty.
  always_comb begin
    jit_sum = $signed({2'b00, base_len}) + $signed({{(CntW - 1){1'b0}}, lfsr_q[2:0]})
              - 18'sd4;
    if (jit_sum < 18'sd1) begin
      range_len = One;
    end else begin
      range_len = jit_sum[CntW-1:0];
    end
  end

  // LFSR advances once per measurement, on the cycle the echo length loads.
  always_comb begin
    lfsr_d = lfsr_q;
    if (state_q == StBurst && tick && tmr_q == BurstLast) begin
      lfsr_d = lfsr_step(lfsr_q);
    end
  end

  // Jitter LFSR register.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      lfsr_q <= LfsrSeed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  // Exact echo length.
  always_comb begin
    range_len = base_len;
  end
`endif

  assign echo_len = in_range ? range_len : Timeout;

  // Measurement FSM: qualify trig, burst delay, echo, holdoff.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    len_d   = len_q;
    dist_d  = dist_q;
    echo_d  = echo_q;
    short_d = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        // Only a fresh rise starts a measurement; a level held high is ignored.
        if (trig_rise) begin
          tmr_d   = '0;
          state_d = StTrigHi;
        end
      end
      StTrigHi: begin
        if (trig_fall) begin
          if (tmr_q >= MinTrig) begin
            dist_d  = dist_cm;
            tmr_d   = '0;
            state_d = StBurst;
          end else begin
            short_d = 1'b1;
            state_d = StIdle;
          end
        end else if (tick && tmr_q < MinTrig) begin
          tmr_d = tmr_q + One;
        end
      end
      StBurst: begin
        // Echo rises on a tick edge, so its width is a whole number of µs.
        if (tick) begin
          if (tmr_q == BurstLast) begin
            echo_d  = 1'b1;
            len_d   = echo_len;
            tmr_d   = '0;
            state_d = StEcho;
          end else begin
            tmr_d = tmr_q + One;
          end
        end
      end
      StEcho: begin
        if (tick) begin
          len_d = len_q - One;
          if (len_q == One) begin
            echo_d  = 1'b0;
            done_d  = 1'b1;
            tmr_d   = '0;
            state_d = StHoldoff;
          end
        end
      end
      StHoldoff: begin
        if (tick) begin
          if (tmr_q == HoldLast) begin
            tmr_d   = '0;
            state_d = StIdle;
          end else begin
            tmr_d = tmr_q + One;
          end
        end
      end
      default: begin
        echo_d  = 1'b0;
        tmr_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  // State, counters, synchroniser and output registers.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      trig_s1_q <= 1'b0;
      trig_s2_q <= 1'b0;
      trig_p_q  <= 1'b0;
      state_q   <= StIdle;
      tmr_q     <= '0;
      len_q     <= '0;
      dist_q    <= '0;
      echo_q    <= 1'b0;
      short_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      trig_s1_q <= trig_s1_d;
      trig_s2_q <= trig_s2_d;
      trig_p_q  <= trig_p_d;
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      len_q     <= len_d;
      dist_q    <= dist_d;
      echo_q    <= echo_d;
      short_q   <= short_d;
      done_q    <= done_d;
    end
  end

  assign echo       = echo_q;
  assign busy       = (state_q != StIdle);
  assign short_trig = short_q;
  assign meas_done  = done_q;

endmodule

// File: tb/tb_hc_sr_sensor_emu.sv
// Scoreboard bench for hc_sr_sensor_emu. Scaled timing parameters keep runs short.
module tb_hc_sr_sensor_emu;

  localparam int FREQ  = 2;
  localparam int MIN_T = 10;
  localparam int BURST = 20;
  localparam int UPC   = 2;
  localparam int MAXC  = 400;
  localparam int TMO   = 900;
  localparam int HOLD  = 30;

  localparam int KShort = 0;
  localparam int KEcho  = 1;
  localparam int KAbort = 2;

  typedef struct {
    int kind;
    int len;
    bit inr;
  } exp_t;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic       trig = 1'b0;
  logic [8:0] dist_cm = 9'd0;
  logic       echo, busy, short_trig, meas_done;

  int     n_cmp = 0;
  int     n_bad = 0;
  longint cyc = 0;
  exp_t   exp_q[$];
  longint width_log[$];

  hc_sr_sensor_emu #(
    .CLK_FREQ_MHZ(FREQ),
    .MIN_TRIG_US (MIN_T),
    .BURST_US    (BURST),
    .US_PER_CM   (UPC),
    .MAX_CM      (MAXC),
    .TIMEOUT_US  (TMO),
    .HOLDOFF_US  (HOLD)
  ) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .trig      (trig),
    .dist_cm   (dist_cm),
    .echo      (echo),
    .busy      (busy),
    .short_trig(short_trig),
    .meas_done (meas_done)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  initial begin
    #(95000 * 10);
    $display("FAIL watchdog: run still active at cycle %0d, required to finish", cyc);
    $fatal(1, "watchdog");
  end

  function automatic int ref_len(input int d);
    return (d == 0 || d > MAXC) ? TMO : d * UPC;
  endfunction

  task automatic check(input string name, input longint act, input longint lo, input longint hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic fail_evt(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event seen at cycle %0d, required none", name, cyc);
  endtask

  // Monitor: pops expectations whenever echo falls or short_trig pulses.
  exp_t   me;
  logic   echo_p = 1'b0;
  longint rise_cyc = 0;
  longint w;
  initial begin
    forever begin
      @(negedge Clk);
      if (echo && !echo_p) rise_cyc = cyc;
      if (!echo && echo_p) begin
        if (exp_q.size() == 0) begin
          fail_evt("unexpected_echo");
        end else begin
          me = exp_q.pop_front();
          w  = cyc - rise_cyc;
          if (me.kind == KAbort) begin
            check("abort_no_meas_done", meas_done, 0, 0);
          end else begin
            check("echo_kind", me.kind, KEcho, KEcho);
            check("meas_done_at_fall", meas_done, 1, 1);
            width_log.push_back(w);
`ifdef HC_SR_SENSOR_EMU_JITTER_EN
            if (me.inr)
              check("echo_width_jit", w, FREQ * ((me.len - 4 < 1) ? 1 : me.len - 4),
                    FREQ * (me.len + 3));
            else
              check("echo_width", w, FREQ * me.len, FREQ * me.len);
`else
            check("echo_width", w, FREQ * me.len, FREQ * me.len);
`endif
          end
        end
      end else if (meas_done) begin
        fail_evt("stray_meas_done");
      end
      if (short_trig) begin
        if (exp_q.size() == 0) begin
          fail_evt("unexpected_short_trig");
        end else begin
          me = exp_q.pop_front();
          check("short_trig_kind", me.kind, KShort, KShort);
        end
      end
      echo_p = echo;
    end
  end

  task automatic tick_cyc();
    @(posedge Clk);
    #1;
  endtask

  // One measurement: trig pulse of tw_us, optional disturbance during echo/holdoff,
  // optional trig held high across the return to idle.
  task automatic run_meas(input int tw_us, input int d, input bit disturb, input bit hold_high);
    exp_t   e;
    longint t_fall, t_efall;
    int     guard;
    bit     seen;
    dist_cm = 9'(d);
    repeat (4) tick_cyc();
    trig = 1'b1;
    repeat (tw_us * FREQ) tick_cyc();
    trig   = 1'b0;
    t_fall = cyc;
    e.kind = (tw_us < MIN_T) ? KShort : KEcho;
    e.len  = ref_len(d);
    e.inr  = (d != 0 && d <= MAXC);
    exp_q.push_back(e);
    if (e.kind == KShort) begin
      guard = 0;
      while (busy && guard < 16) begin tick_cyc(); guard++; end
      check("short_busy_drop", busy, 0, 0);
      check("short_latency", guard, 2, 4);
      return;
    end
    guard = 0;
    while (!echo && guard < (BURST + 2) * FREQ + 10) begin tick_cyc(); guard++; end
    check("burst_delay", cyc - t_fall, BURST * FREQ - FREQ, BURST * FREQ + FREQ + 4);
    guard = 0;
    while (echo && guard < (TMO + 10) * FREQ) begin
      tick_cyc();
      guard++;
      if (disturb) begin
        if ($urandom_range(0, 15) == 0) trig = ~trig;
        if ($urandom_range(0, 31) == 0) dist_cm = 9'($urandom);
      end
    end
    t_efall = cyc;
    if (disturb) begin
      repeat (10 * FREQ) begin
        tick_cyc();
        if ($urandom_range(0, 3) == 0) trig = ~trig;
      end
    end
    trig  = hold_high;
    guard = 0;
    while (busy && guard < (HOLD + 5) * FREQ) begin tick_cyc(); guard++; end
    check("holdoff", cyc - t_efall, HOLD * FREQ - 1, HOLD * FREQ + 1);
    if (hold_high) begin
      seen = 1'b0;
      repeat (40) begin tick_cyc(); seen |= busy; end
      check("held_trig_ignored", seen, 0, 0);
      trig = 1'b0;
    end
  endtask

  // Reset pulsed for one clock mid-echo: echo drops, no meas_done.
  task automatic run_abort(input int d);
    exp_t e;
    int   guard;
    dist_cm = 9'(d);
    repeat (4) tick_cyc();
    trig = 1'b1;
    repeat (12 * FREQ) tick_cyc();
    trig   = 1'b0;
    e.kind = KAbort;
    e.len  = 0;
    e.inr  = 1'b0;
    exp_q.push_back(e);
    guard = 0;
    while (!echo && guard < (BURST + 2) * FREQ + 10) begin tick_cyc(); guard++; end
    check("abort_echo_rose", echo, 1, 1);
    repeat (20) tick_cyc();
    Rst_n = 1'b0;
    tick_cyc();
    check("abort_echo_low", echo, 0, 0);
    check("abort_busy_low", busy, 0, 0);
    check("abort_meas_done_low", meas_done, 0, 0);
    Rst_n = 1'b1;
  endtask

  initial begin
    int guard;
    int tw, d, nd;
    repeat (5) tick_cyc();
    check("rst_echo", echo, 0, 0);
    check("rst_busy", busy, 0, 0);
    check("rst_short_trig", short_trig, 0, 0);
    check("rst_meas_done", meas_done, 0, 0);
    Rst_n = 1'b1;
    repeat (5) tick_cyc();

    run_meas(12, 10, 1'b0, 1'b0);
    run_meas(5, 10, 1'b0, 1'b0);
    run_meas(12, 0, 1'b0, 1'b0);
    run_meas(12, 450, 1'b0, 1'b0);
    run_meas(15, 77, 1'b1, 1'b0);
    run_meas(13, 33, 1'b1, 1'b1);
    run_abort(50);
    run_meas(12, 25, 1'b0, 1'b0);

    for (int i = 0; i < 14; i++) begin
      tw = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : $urandom_range(12, 20);
      case ($urandom_range(0, 7))
        0:       d = 0;
        1:       d = $urandom_range(MAXC + 1, 511);
        default: d = $urandom_range(1, MAXC);
      endcase
      run_meas(tw, d, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end

`ifdef HC_SR_SENSOR_EMU_JITTER_EN
    width_log.delete();
    for (int i = 0; i < 32; i++) run_meas(12, 100, 1'b0, 1'b0);
    nd = 0;
    for (int i = 1; i < width_log.size(); i++) if (width_log[i] != width_log[0]) nd++;
    check("jitter_varies", (nd > 0) ? 1 : 0, 1, 1);
`else
    nd = 0;
`endif

    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin tick_cyc(); guard++; end
    check("leftover_expectations", exp_q.size(), 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hc_sr_sensor_emu.md
Name: hc_sr_sensor_emu

Overview:
Synthesizable HC-SR04 ultrasonic sensor emulator: the responder end of the trig/echo interface driven by the team's range-finder driver. Accepts the host's trig pulse, qualifies its width, waits the emulated burst time, then drives echo high for a width proportional to a programmed distance. Used on-board for loopback bring-up and in simulation as the sensor model behind the driver.

Parameters:
CLK_FREQ_MHZ, 50, Clk frequency in MHz; defines Clk cycles per 1 µs tick
MIN_TRIG_US, 10, minimum qualified trig high width in µs
BURST_US, 200, delay from trig fall to echo rise in µs (emulated 8-cycle 40 kHz burst)
US_PER_CM, 58, echo µs per cm of distance
MAX_CM, 400, largest in-range distance in cm
TIMEOUT_US, 38000, echo width for out-of-range or zero distance
HOLDOFF_US, 1000, recovery time after echo fall before a new trig is accepted

Ports:
Clk  input  1  system clock
Rst_n  input  1  synchronous reset, active-low
trig  input  1  trigger from host; asynchronous, synchronised internally
dist_cm  input  9  emulated target distance in cm; sampled at trig qualification
echo  output  1  echo pulse to host
busy  output  1  high whenever state is not IDLE
short_trig  output  1  one-Clk pulse when a trig shorter than MIN_TRIG_US is rejected
meas_done  output  1  one-Clk pulse on the Clk edge where echo falls

Behaviour:
- Reset: synchronous, active-low, sampled on the rising edge of Clk. While Rst_n=0: echo=0, busy=0, short_trig=0, meas_done=0, state=IDLE, all counters=0, synchroniser flops=0.
- Tick: a free-running counter 0..CLK_FREQ_MHZ-1 produces a one-Clk tick on wrap. All µs timing counts ticks, so every interval is quantised to ±1 tick.
- trig passes through a 2-flop synchroniser before use. Edges are detected on the synchronised signal.
- States:
  - IDLE: a synchronised trig rise clears the width counter and enters TRIG_HI.
  - TRIG_HI: the width counter increments on each tick and saturates at MIN_TRIG_US. On trig fall:
    - if the count is at least MIN_TRIG_US, latch dist_cm, clear the counter and enter BURST;
    - otherwise pulse short_trig and return to IDLE.
  - BURST: after BURST_US ticks, set echo=1 on that Clk edge and load the echo length.
    - Echo length is dist_cm*US_PER_CM when 1 <= dist_cm <= MAX_CM.
    - Echo length is TIMEOUT_US when dist_cm=0 or dist_cm>MAX_CM.
  - ECHO: the length counter decrements each tick. On reaching 0: echo=0, pulse meas_done, enter HOLDOFF. Echo width is exactly length*CLK_FREQ_MHZ Clk cycles.
  - HOLDOFF: wait HOLDOFF_US ticks, then return to IDLE. A trig still high on return is ignored until it falls and rises again; IDLE accepts rises only.
- Trig activity in BURST, ECHO or HOLDOFF is ignored and does not restart the measurement.
- dist_cm changes after qualification do not affect the echo in progress.
- Arithmetic: the product is 9b x const, computed into a 16-bit counter. All duration parameters must be <= 65535; this is checked by an elaboration-time assertion.
- Reset asserted mid-ECHO drops echo to 0 on that edge, with no meas_done pulse.
- Trig held high indefinitely: remain in TRIG_HI with the counter saturated, and act on the eventual fall.

Optional Feature:
- Macro: HC_SR_SENSOR_EMU_JITTER_EN.
- When defined: a 16-bit Galois LFSR (seed 16'hACE1 on reset, stepped once per measurement) adds a signed offset of -4..+3 ticks (LFSR[2:0] minus 4) to the in-range echo length. The result is clamped to a minimum of 1. The TIMEOUT_US length is unaffected.
- When undefined: no LFSR exists and the echo length is exact.

Decomposition:
- Package hc_sr_pkg holds:
  - state encoding: IDLE, TRIG_HI, BURST, ECHO, HOLDOFF;
  - default constants: US_PER_CM, MIN_TRIG_US, TIMEOUT_US, MAX_CM;
  - the 16-bit counter width localparam.
- Sub-module hc_sr_us_tick: parameter CLK_FREQ_MHZ, ports Clk, Rst_n, tick. It produces a one-cycle enable rather than a derived clock, keeping the design on a single clock.

Test Plan:
- Reset, CLK_FREQ_MHZ=50, dist_cm=10, trig high 12 µs -> echo rises 200±1 µs after trig fall, width exactly 580 µs (29000 Clk), meas_done one pulse, busy low 1000±1 µs after echo fall.
- trig high 5 µs -> no echo, short_trig one pulse about 2 Clk after trig fall, busy low again.
- dist_cm=0, then dist_cm=450 -> each gives echo width 38000 µs.
- Retrigger during ECHO and during HOLDOFF, and change dist_cm mid-ECHO -> echo width unchanged, no second echo until after HOLDOFF plus a fresh trig rise.
- Rst_n=0 for one Clk mid-ECHO -> echo=0 on the next edge, no meas_done; a subsequent normal trig yields a correct echo.
- With HC_SR_SENSOR_EMU_JITTER_EN, dist_cm=100 over 32 measurements -> every width is within 5796..5803 µs and not all widths are equal.
